pc_sequencer: RTL

Program-counter and control-flow sequencer sitting directly upstream of the single-entry call register. It owns `counter`, advancing it on each accepted instruction. It redirects `counter` on jump, call, return and skip. During a call it drives `cal_f` for one cycle, so the call register captures the calling address. On return it resumes at the captured `ret_addr`+1. It models a one-cycle fetch bubble after every redirect and supports halt/resume.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter and control-flow sequencer feeding the
// single-entry call register and the instruction fetch.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active-high
//   stall        freeze: no state change, no accept, cal_f forced low
//   op_valid     decoded op of the instruction at counter is present
//   op_jmp       unconditional jump to target
//   op_cal       call to target (call register saves counter)
//   op_ret       return to ret_addr+1
//   op_skip      conditional skip of the next instruction
//   skip_cond    skip is taken when high
//   op_hlt       halt
//   resume       leave HALT
//   target       jump/call destination
//   ret_addr     saved calling address from the call register
//   counter      current instruction address (registered)
//   cal_f        call strobe to the call register (combinational)
//   fetch_valid  instruction at counter is valid (registered)
//   halted       sequencer is in HALT (registered)
module pc_sequencer #(
  parameter int                    CNTR_WIDTH   = 8,
  parameter logic [CNTR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  op_valid,
  input  logic                  op_jmp,
  input  logic                  op_cal,
  input  logic                  op_ret,
  input  logic                  op_skip,
  input  logic                  skip_cond,
  input  logic                  op_hlt,
  input  logic                  resume,
  input  logic [CNTR_WIDTH-1:0] target,
  input  logic [CNTR_WIDTH-1:0] ret_addr,
  output logic [CNTR_WIDTH-1:0] counter,
  output logic                  cal_f,
  output logic                  fetch_valid,
  output logic                  halted
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNTR_WIDTH-1:0] TWO = {{(CNTR_WIDTH-2){1'b0}}, 2'b10};

  state_t state;
  logic   accept;

  // Address arithmetic deliberately wraps at CNTR_WIDTH bits.
  function automatic logic [CNTR_WIDTH-1:0] add_wrap(
    input logic [CNTR_WIDTH-1:0] a,
    input logic [CNTR_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  assign accept = (state == S_RUN) & op_valid & ~stall & ~rst;

  // Combinational so the strobe coincides with counter still holding the
  // calling address; the call register captures it on this same edge.
  assign cal_f = accept & op_cal & ~op_ret & ~op_hlt;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= RESET_VECTOR;
      state       <= S_FLUSH;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        S_RUN: begin
          if (accept) begin
            // Priority: hlt > ret > cal > jmp > skip > increment.
            if (op_hlt) begin
              state       <= S_HALT;
              fetch_valid <= 1'b0;
              halted      <= 1'b1;
            end else if (op_ret) begin
              counter     <= add_wrap(ret_addr, ONE);
              state       <= S_FLUSH;
              fetch_valid <= 1'b0;
            end else if (op_cal || op_jmp) begin
              counter     <= target;
              state       <= S_FLUSH;
              fetch_valid <= 1'b0;
            end else if (op_skip && skip_cond) begin
              counter     <= add_wrap(counter, TWO);
              state       <= S_FLUSH;
              fetch_valid <= 1'b0;
            end else begin
              // Straight-line flow: no bubble.
              counter <= add_wrap(counter, ONE);
            end
          end
        end
        S_FLUSH: begin
          // One-cycle fetch bubble after any redirect or reset.
          state       <= S_RUN;
          fetch_valid <= 1'b1;
        end
        S_HALT: begin
          if (resume) begin
            counter <= add_wrap(counter, ONE);
            state   <= S_FLUSH;
            halted  <= 1'b0;
          end
        end
        default: begin
          state       <= S_FLUSH;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
